// File: rtl/jtkcpu_intseq.sv
// KCPU interrupt and reset sequencer.
// Samples the IRQ/FIRQ/NMI pins and applies the CC masks and source priority.
// At instruction boundaries it runs the stacking handshake. It then presents
// the one-hot vector code and holds it until the memory controller reloads PC.
// After reset it issues the reset vector fetch.
module jtkcpu_intseq #(
    parameter bit NMI_ARM_RST = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       irq_n,
    input  logic       firq_n,
    input  logic       nmi_n,
    input  logic       nmi_arm,
    input  logic       cc_i,
    input  logic       cc_f,
    input  logic       ins_end,
    input  logic       push_done,
    input  logic       up_pc,
    output logic       push_req,
    output logic       push_all,
    output logic       set_e,
    output logic       set_i,
    output logic       set_f,
    output logic [3:0] intvec,
    output logic       int_busy,
    output logic       nmi_pend
);

    typedef enum logic [1:0] {
        RSTV,
        IDLE,
        PUSH,
        VEC
    } state_t;

    localparam logic [3:0] VEC_NONE = 4'b0000;
    localparam logic [3:0] VEC_IRQ  = 4'b0001;
    localparam logic [3:0] VEC_FIRQ = 4'b0010;
    localparam logic [3:0] VEC_NMI  = 4'b0100;
    localparam logic [3:0] VEC_RST  = 4'b1000;

    state_t     state;
    logic [3:0] src;        // source frozen at acceptance
    logic       irq_s;
    logic       firq_s;
    logic       nmi_s;
    logic       nmi_sl;     // previous NMI sample, for edge detection
    logic       nmi_armed;
    logic       nmi_edge;
    logic       nmi_clr;
    logic       irq_p;
    logic       firq_p;
    logic [3:0] win;

    // Pending sources and priority winner (NMI > FIRQ > IRQ)
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        win      = VEC_NONE;
        nmi_edge = nmi_sl & ~nmi_s;
        firq_p   = ~firq_s & ~cc_f;
        irq_p    = ~irq_s & ~cc_i;
        nmi_clr  = (state == VEC) && up_pc && (src == VEC_NMI);
        if (nmi_pend)
            win = VEC_NMI;
        else if (firq_p)
            win = VEC_FIRQ;
        else if (irq_p)
            win = VEC_IRQ;
    end

    // Register the interrupt pins once per CPU cycle
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            irq_s  <= 1'b1;
            firq_s <= 1'b1;
            nmi_s  <= 1'b1;
            nmi_sl <= 1'b1;
        end else if (cen) begin
            irq_s  <= irq_n;
            firq_s <= firq_n;
            nmi_s  <= nmi_n;
            nmi_sl <= nmi_s;
        end
    end

    // NMI arming and edge latch; a new edge wins over the service clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_armed <= NMI_ARM_RST;
            nmi_pend  <= 1'b0;
        end else if (cen) begin
            if (nmi_arm)
                nmi_armed <= 1'b1;
            if (nmi_edge && nmi_armed)
                nmi_pend <= 1'b1;
            else if (nmi_clr)
                nmi_pend <= 1'b0;
        end
    end

    // Sequencer FSM with registered handshake and vector outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RSTV;
            src      <= VEC_NONE;
            intvec   <= VEC_RST;
            int_busy <= 1'b1;
            push_req <= 1'b0;
            push_all <= 1'b0;
            set_e    <= 1'b0;
            set_i    <= 1'b0;
            set_f    <= 1'b0;
        end else if (cen) begin
            // Pulses drop at the next enabled edge so they last one CPU cycle.
            push_req <= 1'b0;
            set_e    <= 1'b0;
            set_i    <= 1'b0;
            set_f    <= 1'b0;
            case (state)
                RSTV: begin
                    if (up_pc) begin
                        state    <= IDLE;
                        intvec   <= VEC_NONE;
                        int_busy <= 1'b0;
                        set_i    <= 1'b1;
                        set_f    <= 1'b1;
                    end
                end
                IDLE: begin
                    if (ins_end && (win != VEC_NONE)) begin
                        state    <= PUSH;
                        src      <= win;
                        int_busy <= 1'b1;
                        push_req <= 1'b1;
                        set_e    <= 1'b1;
                        push_all <= (win != VEC_FIRQ);
                    end
                end
                PUSH: begin
                    if (push_done) begin
                        state  <= VEC;
                        intvec <= src;
                    end
                end
                VEC: begin
                    if (up_pc) begin
                        state    <= IDLE;
                        intvec   <= VEC_NONE;
                        int_busy <= 1'b0;
                        set_i    <= 1'b1;
                        set_f    <= (src != VEC_IRQ);
                    end
                end
                default: begin
                    state <= RSTV;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtkcpu_intseq.sv
// Self-checking bench for jtkcpu_intseq: directed scenarios followed by
// randomized pin/mask traffic checked against a transaction-level model.
module tb_jtkcpu_intseq;

    localparam bit NMI_ARM_RST = 1'b0;

    logic       clk = 1'b0;
    logic       rst;
    logic       cen;
    logic       irq_n, firq_n, nmi_n, nmi_arm;
    logic       cc_i, cc_f;
    logic       ins_end, push_done, up_pc;
    logic       push_req, push_all, set_e, set_i, set_f;
    logic [3:0] intvec;
    logic       int_busy, nmi_pend;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: NMI armed flag and NMI latch
    bit m_armed = NMI_ARM_RST;
    bit m_npend = 1'b0;

    jtkcpu_intseq #(.NMI_ARM_RST(NMI_ARM_RST)) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .irq_n    (irq_n),
        .firq_n   (firq_n),
        .nmi_n    (nmi_n),
        .nmi_arm  (nmi_arm),
        .cc_i     (cc_i),
        .cc_f     (cc_f),
        .ins_end  (ins_end),
        .push_done(push_done),
        .up_pc    (up_pc),
        .push_req (push_req),
        .push_all (push_all),
        .set_e    (set_e),
        .set_i    (set_i),
        .set_f    (set_f),
        .intvec   (intvec),
        .int_busy (int_busy),
        .nmi_pend (nmi_pend)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One CPU cycle: a few random cen=0 clocks, then one enabled edge.
    task automatic cyc();
        int gap = $urandom_range(0, 2);
        repeat (gap) begin
            cen = 1'b0;
            @(posedge clk);
            #1;
        end
        cen = 1'b1;
        @(posedge clk);
        #1;
        cen = 1'b0;
    endtask

    // Drive pin levels and let the samplers settle; the model latches armed NMI falls.
    task automatic set_pins(input logic irq, input logic firq, input logic nmi);
        if (nmi_n && !nmi && m_armed)
            m_npend = 1'b1;
        irq_n  = irq;
        firq_n = firq;
        nmi_n  = nmi;
        cyc();
        cyc();
    endtask

    task automatic arm();
        nmi_arm = 1'b1;
        cyc();
        nmi_arm = 1'b0;
        m_armed = 1'b1;
    endtask

    // Priority rule: 2 = NMI, 1 = FIRQ, 0 = IRQ, -1 = none
    function automatic int winner();
        if (m_npend)
            return 2;
        if (!firq_n && !cc_f)
            return 1;
        if (!irq_n && !cc_i)
            return 0;
        return -1;
    endfunction

    // One instruction boundary and, if something is pending, a full interrupt sequence.
    task automatic do_int(input bit inj, input bit edge_clr);
        int         w = winner();
        int         n;
        bit         keep = 1'b0;
        logic [3:0] v;
        ins_end = 1'b1;
        cyc();
        ins_end = 1'b0;
        if (w < 0) begin
            check("idle_push_req", push_req, 0);
            check("idle_busy", int_busy, 0);
            check("idle_vec", intvec, 0);
            return;
        end
        v = 4'(1 << w);
        check("acc_push_req", push_req, 1);
        check("acc_set_e", set_e, 1);
        check("acc_push_all", push_all, 32'(w != 1));
        check("acc_busy", int_busy, 1);
        check("acc_vec", intvec, 0);
        n = $urandom_range(0, 2);
        if (inj && w != 2) begin
            set_pins(irq_n, firq_n, ~nmi_n);
            check("push_req_drop", push_req, 0);
        end
        repeat (n) begin
            up_pc   = 1'b1;
            ins_end = 1'($urandom_range(0, 1));
            cyc();
            up_pc   = 1'b0;
            ins_end = 1'b0;
            check("push_hold_req", push_req, 0);
            check("push_hold_vec", intvec, 0);
        end
        push_done = 1'b1;
        cyc();
        push_done = 1'b0;
        check("vec_code", intvec, 32'(v));
        check("vec_busy", int_busy, 1);
        check("vec_push_req", push_req, 0);
        repeat ($urandom_range(0, 2)) begin
            ins_end   = 1'b1;
            push_done = 1'b1;
            cyc();
            ins_end   = 1'b0;
            push_done = 1'b0;
            check("vec_hold", intvec, 32'(v));
        end
        if (edge_clr && w == 2 && nmi_n) begin
            nmi_n = 1'b0;
            cyc();
            keep = m_armed;
        end
        up_pc = 1'b1;
        cyc();
        up_pc = 1'b0;
        if (w == 2)
            m_npend = keep;
        check("done_set_i", set_i, 1);
        check("done_set_f", set_f, 32'(w != 0));
        check("done_vec", intvec, 0);
        check("done_busy", int_busy, 0);
        check("done_nmi_pend", nmi_pend, 32'(m_npend));
        cyc();
        check("mask_pulse_i_end", set_i, 0);
        check("mask_pulse_f_end", set_f, 0);
    endtask

    initial begin
        rst       = 1'b1;
        cen       = 1'b0;
        irq_n     = 1'b1;
        firq_n    = 1'b1;
        nmi_n     = 1'b1;
        nmi_arm   = 1'b0;
        cc_i      = 1'b1;
        cc_f      = 1'b1;
        ins_end   = 1'b0;
        push_done = 1'b0;
        up_pc     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vec", intvec, 4'b1000);
        check("rst_busy", int_busy, 1);
        check("rst_push_req", push_req, 0);
        check("rst_nmi_pend", nmi_pend, 0);
        check("rst_set_i", set_i, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: reset vector fetch; stray pulses are ignored in RSTV
        ins_end   = 1'b1;
        push_done = 1'b1;
        cyc();
        ins_end   = 1'b0;
        push_done = 1'b0;
        check("rstv_hold_vec", intvec, 4'b1000);
        check("rstv_hold_busy", int_busy, 1);
        check("rstv_no_push", push_req, 0);
        up_pc = 1'b1;
        cyc();
        up_pc = 1'b0;
        check("rstv_set_i", set_i, 1);
        check("rstv_set_f", set_f, 1);
        check("rstv_exit_vec", intvec, 0);
        check("rstv_exit_busy", int_busy, 0);
        check("rstv_exit_push", push_req, 0);
        cyc();
        check("rstv_pulse_end", set_i, 0);

        // 2: plain IRQ
        cc_i = 1'b0;
        set_pins(1'b0, 1'b1, 1'b1);
        do_int(1'b0, 1'b0);

        // 3: FIRQ beats IRQ, IRQ follows once FIRQ is masked
        cc_f = 1'b0;
        set_pins(1'b0, 1'b0, 1'b1);
        do_int(1'b0, 1'b0);
        cc_f = 1'b1;
        do_int(1'b0, 1'b0);

        // 4: NMI arming, masks do not affect NMI, edge during clear survives
        cc_i = 1'b1;
        set_pins(1'b1, 1'b1, 1'b0);
        check("nmi_disarmed", nmi_pend, 0);
        set_pins(1'b1, 1'b1, 1'b1);
        arm();
        set_pins(1'b1, 1'b1, 1'b0);
        check("nmi_armed_edge", nmi_pend, 1);
        do_int(1'b0, 1'b0);
        set_pins(1'b1, 1'b1, 1'b1);
        set_pins(1'b1, 1'b1, 1'b0);
        set_pins(1'b1, 1'b1, 1'b1);
        do_int(1'b0, 1'b1);
        check("nmi_edge_at_clear", nmi_pend, 1);
        do_int(1'b0, 1'b0);

        // 5: NMI edge during an IRQ sequence is kept and taken next
        cc_i = 1'b0;
        set_pins(1'b0, 1'b1, 1'b1);
        do_int(1'b1, 1'b0);
        check("nmi_kept", nmi_pend, 1);
        do_int(1'b0, 1'b0);

        // 6: asynchronous reset in VEC
        set_pins(1'b0, 1'b1, 1'b1);
        ins_end = 1'b1;
        cyc();
        ins_end = 1'b0;
        set_pins(1'b0, 1'b1, 1'b0);
        push_done = 1'b1;
        cyc();
        push_done = 1'b0;
        check("pre_rst_vec", intvec, 4'b0001);
        check("pre_rst_nmi", nmi_pend, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_vec", intvec, 4'b1000);
        check("arst_push_req", push_req, 0);
        check("arst_busy", int_busy, 1);
        check("arst_nmi_pend", nmi_pend, 0);
        m_armed = NMI_ARM_RST;
        m_npend = 1'b0;
        irq_n   = 1'b1;
        firq_n  = 1'b1;
        nmi_n   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cyc();
        check("post_rst_vec", intvec, 4'b1000);
        set_pins(1'b1, 1'b1, 1'b0);
        check("post_rst_armed", nmi_pend, 32'(m_npend));
        set_pins(1'b1, 1'b1, 1'b1);
        up_pc = 1'b1;
        cyc();
        up_pc = 1'b0;
        check("post_rst_exit", intvec, 0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            cc_i = 1'($urandom_range(0, 1));
            cc_f = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0)
                arm();
            set_pins(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
            check("rnd_nmi_pend", nmi_pend, 32'(m_npend));
            do_int(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/jtkcpu_intseq.md
Name: jtkcpu_intseq

Overview:
Interrupt and reset sequencer for the KCPU core. Samples the IRQ/FIRQ/NMI pins, applies CC masking and priority, and at instruction boundaries drives the stacking handshake. It then presents the one-hot vector code (intvec) to the memory controller and holds it until the controller confirms the PC reload (up_pc). It also issues the reset vector fetch after reset.

Parameters:
NMI_ARM_RST, 0, NMI acceptance state after reset (0 = disarmed until nmi_arm pulse)

Ports:
clk        in   1  clock
rst        in   1  reset, asynchronous, active-high
cen        in   1  CPU clock enable; all state advances only when cen=1
irq_n      in   1  IRQ pin, level, active-low
firq_n     in   1  FIRQ pin, level, active-low
nmi_n      in   1  NMI pin, falling-edge triggered
nmi_arm    in   1  pulse: S register written, NMI enabled from now on
cc_i       in   1  CC I mask (1 = IRQ masked)
cc_f       in   1  CC F mask (1 = FIRQ masked)
ins_end    in   1  pulse: current instruction completes this cen cycle
push_done  in   1  pulse: stacking unit finished
up_pc      in   1  pulse from memory controller: PC loaded from vector
push_req   out  1  one-cen pulse: start stacking
push_all   out  1  valid with push_req: 1 = full frame (E=1), 0 = PC+CC only (E=0)
set_e      out  1  one-cen pulse: write CC.E = push_all, issued with push_req
set_i      out  1  one-cen pulse: set CC.I
set_f      out  1  one-cen pulse: set CC.F
intvec     out  4  one-hot vector code: 0001 IRQ, 0010 FIRQ, 0100 NMI, 1000 RST, 0000 none
int_busy   out  1  high from acceptance until up_pc
nmi_pend   out  1  latched NMI pending flag (debug/observability)

Behaviour:
- Reset values:
  - state=RSTV; intvec=4'b1000; int_busy=1.
  - push_req, push_all, set_e, set_i, set_f all 0.
  - nmi_pend=0; NMI armed flag = NMI_ARM_RST; pin sample registers = 1.
- Pin sampling:
  - irq_n, firq_n and nmi_n are registered on cen, giving one cen cycle of latency.
  - NMI edge = previous sample 1, current sample 0.
  - An NMI edge while armed sets nmi_pend; an edge while disarmed is discarded.
  - nmi_arm sets the armed flag; only rst clears it.
- Pending:
  - firq_p = !firq_s && !cc_f.
  - irq_p = !irq_s && !cc_i.
  - Priority: NMI > FIRQ > IRQ.
- States:
  - RSTV: intvec=1000 held. On up_pc -> IDLE, with set_i=1 and set_f=1 for one cen cycle. No push.
  - IDLE: intvec=0, int_busy=0. On ins_end with any pending source, latch the winner -> PUSH. Without ins_end, stay.
  - PUSH:
    - On the first cycle, issue push_req and set_e.
    - push_all=1 for NMI/IRQ, 0 for FIRQ.
    - Wait for push_done -> VEC. push_done in the same cycle as push_req is legal.
  - VEC:
    - intvec = latched source, held constant.
    - On up_pc -> IDLE, and pulse the masks in the same cycle:
      - IRQ: set_i.
      - FIRQ: set_i and set_f.
      - NMI: set_i and set_f; clear nmi_pend.
- Boundary cases:
  - Source selection is frozen at ins_end. A higher-priority request arriving in PUSH/VEC stays pending and is taken at the next ins_end. NMI edges in PUSH/VEC are latched, never lost.
  - An NMI edge in the same cycle nmi_pend is being cleared leaves nmi_pend=1.
  - A request deasserted after acceptance still completes its sequence.
  - ins_end while not IDLE is ignored.
  - push_done or up_pc in the wrong state is ignored.
  - rst asserted mid-sequence aborts immediately to reset values and restarts RSTV.
  - cen=0 freezes all state; pulses are single cen cycles, not single clk cycles.

Test Plan:
1. Release rst, hold pins high -> intvec=1000, int_busy=1. Pulse up_pc -> set_i=set_f=1 for one cen, intvec=0, int_busy=0.
2. cc_i=0, irq_n=0, pulse ins_end -> push_req=1 with push_all=1, set_e=1. Pulse push_done -> intvec=0001. Pulse up_pc -> set_i=1, set_f=0.
3. cc_f=0, cc_i=0, firq_n=0 and irq_n=0 together, then ins_end -> FIRQ wins: push_all=0, intvec=0010, set_i=set_f=1 on up_pc. IRQ is taken on the next ins_end.
4. NMI falling edge before nmi_arm -> nmi_pend stays 0. After nmi_arm, edge -> nmi_pend=1. ins_end -> intvec=0100, cc_f/cc_i=1 ignored; nmi_pend=0 after up_pc.
5. IRQ accepted, NMI edge during PUSH -> sequence completes with intvec=0001, nmi_pend=1. Next ins_end -> intvec=0100.
6. Assert rst while in VEC with intvec=0001 -> intvec=1000 and push_req=0 asynchronously; nmi_pend=0; armed flag back to NMI_ARM_RST.
